// File: rtl/gray_step_decoder_pkg.sv
// Shared constants for the 3-bit Gray step decoder: FSM encoding, Gray codes and step deltas.
package gray_step_decoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t TRACK = 2'b01;
  localparam state_t FAULT = 2'b10;

  // Gray sequence, positions 0..7, identical to the counter's s0..s7
  localparam logic [2:0] G0 = 3'b000;
  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b011;
  localparam logic [2:0] G3 = 3'b010;
  localparam logic [2:0] G4 = 3'b110;
  localparam logic [2:0] G5 = 3'b111;
  localparam logic [2:0] G6 = 3'b101;
  localparam logic [2:0] G7 = 3'b100;

  localparam logic [2:0] DELTA_UP = 3'd1;
  localparam logic [2:0] DELTA_DN = 3'd7;

endpackage

// File: rtl/gray_step_decoder_gray3_to_bin.sv
// Combinational 3-bit Gray to binary conversion.
module gray3_to_bin (
  input  logic [2:0] gray,
  output logic [2:0] bin
);

  always_comb begin
    bin[2] = gray[2];
    bin[1] = gray[2] ^ gray[1];
    bin[0] = bin[1] ^ gray[0];
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Decodes a sampled 3-bit Gray code into binary, tracks step direction and accumulates
// a wrapping signed position; multi-bit jumps latch a fault until clr_err.
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int unsigned POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       gray_in,
  input  logic             clr_err,
  output logic [2:0]       bin_out,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  state_t           state_q, state_d;
  logic [2:0]       g_last_q, g_last_d;
  logic [2:0]       bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [2:0]       b_new;
  logic [2:0]       b_last;
  logic [2:0]       delta;

  gray3_to_bin u_dec_new (
    .gray (gray_in),
    .bin  (b_new)
  );

  gray3_to_bin u_dec_last (
    .gray (g_last_q),
    .bin  (b_last)
  );

  always_comb begin
    state_d  = state_q;
    g_last_d = g_last_q;
    bin_d    = bin_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = err_q;
    delta    = b_new - b_last;

    case (state_q)
      IDLE: begin
        if (en) begin
          g_last_d = gray_in;
          bin_d    = b_new;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (en) begin
          if (delta == DELTA_UP) begin
            pos_d    = pos_q + 1'b1;
            dir_d    = 1'b1;
            step_d   = 1'b1;
            wrap_d   = (b_last == 3'd7);
            g_last_d = gray_in;
            bin_d    = b_new;
          end else if (delta == DELTA_DN) begin
            pos_d    = pos_q - 1'b1;
            dir_d    = 1'b0;
            step_d   = 1'b1;
            wrap_d   = (b_last == 3'd0);
            g_last_d = gray_in;
            bin_d    = b_new;
          end else if (delta != 3'd0) begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        // resync does not require en: the source may be paused while recovering
        if (clr_err) begin
          g_last_d = gray_in;
          bin_d    = b_new;
          err_d    = 1'b0;
          state_d  = TRACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      g_last_q <= '0;
      bin_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b1;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_last_q <= g_last_d;
      bin_q    <= bin_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign pos     = pos_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Randomised and directed check of gray_step_decoder against a position-table reference model.
module tb_gray_step_decoder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  gray_in;
  logic        clr_err;

  logic [2:0]  bin16, bin4;
  logic [15:0] pos16;
  logic [3:0]  pos4;
  logic        dir16, dir4, step16, step4, wrap16, wrap4, err16, err4;

  int unsigned n_checks;
  int unsigned n_fail;

  // reference model: Gray sequence table, positions as plain integers
  logic [2:0] gtab [8];
  bit  m_started, m_fault, m_dir, m_step, m_wrap;
  int  m_last;
  int  m_pos;
  int  cur_idx;

  gray_step_decoder #(.POS_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin16), .pos(pos16), .dir(dir16), .step(step16), .wrap(wrap16), .err(err16)
  );

  gray_step_decoder #(.POS_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin4), .pos(pos4), .dir(dir4), .step(step4), .wrap(wrap4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [2:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (gtab[i] == g) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_started = 0; m_fault = 0; m_dir = 1; m_step = 0; m_wrap = 0;
    m_last = 0; m_pos = 0;
  endtask

  task automatic model_step(input bit e, input logic [2:0] g, input bit c);
    int bn, d;
    bn = pos_of(g);
    d  = (bn - m_last + 8) % 8;
    m_step = 0; m_wrap = 0;
    if (m_fault) begin
      if (c) begin m_fault = 0; m_last = bn; end
    end else if (!m_started) begin
      if (e) begin m_started = 1; m_last = bn; end
    end else if (e) begin
      if (d == 1) begin
        m_step = 1; m_wrap = (m_last == 7); m_dir = 1; m_pos++; m_last = bn;
      end else if (d == 7) begin
        m_step = 1; m_wrap = (m_last == 0); m_dir = 0; m_pos--; m_last = bn;
      end else if (d != 0) begin
        m_fault = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] p16;
    logic [3:0]  p4;
    p16 = m_pos[15:0];
    p4  = m_pos[3:0];
    check_eq({tag, ".bin"},  bin16,  m_last[2:0]);
    check_eq({tag, ".pos"},  pos16,  p16);
    check_eq({tag, ".dir"},  dir16,  m_dir);
    check_eq({tag, ".step"}, step16, m_step);
    check_eq({tag, ".wrap"}, wrap16, m_wrap);
    check_eq({tag, ".err"},  err16,  m_fault);
    check_eq({tag, ".pos4"}, pos4,   p4);
    check_eq({tag, ".bin4"}, bin4,   m_last[2:0]);
    check_eq({tag, ".err4"}, err4,   m_fault);
    check_eq({tag, ".stp4"}, {wrap4, step4, dir4}, {m_wrap, m_step, m_dir});
  endtask

  // called just after a falling edge: drive, let one rising edge pass, sample on the next fall
  task automatic tick(input string tag, input bit e, input logic [2:0] g, input bit c);
    en = e; gray_in = g; clr_err = c;
    model_step(e, g, c);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    int r;
    int nxt;
    bit e, c;
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
    n_checks = 0; n_fail = 0;
    en = 0; gray_in = 3'b000; clr_err = 0; rst = 1;
    @(negedge clk);
    do_reset("rst0");

    // 1: first sample never steps
    tick("t1", 1, 3'b011, 0);
    check_eq("t1_bin2", bin16, 3'd2);
    tick("t1b", 1, 3'b011, 0);

    // 2: full lap upward
    do_reset("rst2");
    tick("t2s", 1, 3'b000, 0);
    for (int i = 1; i <= 8; i++) tick("t2", 1, gtab[i % 8], 0);
    check_eq("t2_pos8", pos16, 16'd8);

    // 3: down across the 0/7 boundary
    do_reset("rst3");
    tick("t3s", 1, 3'b000, 0);
    tick("t3a", 1, 3'b100, 0);
    check_eq("t3_neg1", pos16, 16'hffff);
    tick("t3b", 1, 3'b101, 0);

    // 4: illegal jump, ignored inputs, resync
    do_reset("rst4");
    tick("t4s", 1, 3'b001, 0);
    tick("t4a", 1, 3'b010, 0);
    tick("t4b", 1, 3'b011, 0);
    tick("t4c", 0, 3'b111, 0);
    tick("t4d", 0, 3'b110, 1);
    check_eq("t4_bin4", bin16, 3'd4);
    tick("t4e", 1, 3'b111, 1);

    // 5: en=0 holds, then a 2-position jump
    do_reset("rst5");
    tick("t5s", 1, 3'b000, 0);
    tick("t5a", 0, 3'b001, 0);
    tick("t5b", 0, 3'b011, 0);
    tick("t5c", 1, 3'b011, 0);
    check_eq("t5_err", err16, 1'b1);

    // 6: reset mid-run at pos=5, then 17 up steps for the 4-bit wrap
    do_reset("rst6");
    tick("t6s", 1, 3'b000, 0);
    for (int i = 1; i <= 5; i++) tick("t6a", 1, gtab[i], 0);
    do_reset("rst6m");
    tick("t6t", 1, 3'b000, 0);
    for (int i = 1; i <= 17; i++) tick("t6b", 1, gtab[i % 8], 0);
    check_eq("t6_pos4", pos4, 4'd1);

    // random phase: mostly single steps, occasional jumps, pauses and clears
    do_reset("rstr");
    cur_idx = 0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      nxt = (cur_idx + 1) % 8;
      else if (r < 75) nxt = (cur_idx + 7) % 8;
      else if (r < 88) nxt = cur_idx;
      else             nxt = $urandom_range(0, 7);
      cur_idx = nxt;
      e = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 8);
      tick("rnd", e, gtab[nxt], c);
      if (k == 250) do_reset("rstrm");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
